// File: rtl/clic_apb_lite.sv
// Small APB-programmed core-local interrupt controller: level arbitration, threshold compare, ack bubble.
// Edge-triggered sources are available when CLIC_EDGE_TRIG_EN is defined.
package CC_ITF_PKG;
   localparam int unsigned APB_AW = 32;
   localparam int unsigned APB_DW = 32;

   typedef struct packed {
      logic              psel;
      logic              penable;
      logic              pwrite;
      logic [APB_AW-1:0] paddr;
      logic [APB_DW-1:0] pwdata;
   } apb_d32_req_t;

   typedef struct packed {
      logic [APB_DW-1:0] prdata;
      logic              pready;
      logic              pslverr;
   } apb_d32_resps_t;
endpackage

module clic_apb_lite #(
   parameter int unsigned NUM_IRQ = 32,
   parameter int unsigned ID_W    = 5,
   parameter int unsigned LVL_W   = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [NUM_IRQ-1:0]         irq_src_i,
   input  CC_ITF_PKG::apb_d32_req_t   apb_req_i,
   output CC_ITF_PKG::apb_d32_resps_t apb_rsp_o,
   output logic                       irq_req_o,
   output logic                       irq_shv_o,
   output logic [ID_W-1:0]            irq_id_o,
   output logic [LVL_W-1:0]           irq_level_o,
   input  logic                       irq_ack_i,
   input  logic [LVL_W-1:0]           intthresh_i,
   input  logic                       mnxti_clr_i,
   input  logic [ID_W-1:0]            mnxti_id_i
);
   localparam int unsigned IDX_W = 6;

   logic [NUM_IRQ-1:0] ip_q;
   logic [NUM_IRQ-1:0] ip_d;
   logic [NUM_IRQ-1:0] ie_q;
   logic [NUM_IRQ-1:0] shv_q;
   logic [LVL_W-1:0]   lvl_q [NUM_IRQ];
   logic [NUM_IRQ-1:0] ctrl_wr;

   logic [31:0]        paddr;
   logic [31:0]        pwdata;
   logic [IDX_W-1:0]   idx;
   logic               is_info;
   logic               is_ctrl;
   logic               wr_en;
   logic [31:0]        rdata;

   logic               any_cand;
   logic [ID_W-1:0]    win_id;
   logic [LVL_W-1:0]   win_lvl;
   logic               win_shv;
   logic               req_nxt;

   assign paddr   = apb_req_i.paddr;
   assign pwdata  = apb_req_i.pwdata;
   assign idx     = paddr[7:2];
   assign is_info = (paddr[31:2] == 30'd0);
   assign is_ctrl = (paddr[31:8] == 24'h1) && (32'(idx) < NUM_IRQ);
   assign wr_en   = apb_req_i.psel & apb_req_i.penable & apb_req_i.pwrite;

`ifdef CLIC_EDGE_TRIG_EN
   logic [NUM_IRQ-1:0] trig_q;
   logic [NUM_IRQ-1:0] src_d_q;
   logic               unused_bits;
   assign unused_bits = ^{paddr[1:0], pwdata[7:1], pwdata[15:9], pwdata[23:18]};
`else
   logic               unused_bits;
   assign unused_bits = ^{paddr[1:0], pwdata[7:0], pwdata[15:9], pwdata[23:17],
                          mnxti_clr_i, mnxti_id_i};
`endif

   // Per-source write strobe; out-of-range indices never match
   always_comb begin
      ctrl_wr = '0;
      for (int i = 0; i < int'(NUM_IRQ); i++) begin
         ctrl_wr[i] = wr_en & is_ctrl & (idx == IDX_W'(i));
      end
   end

   // Combinational read data and error response
   always_comb begin
      rdata = '0;
      if (is_info) begin
         rdata = {16'd0, 8'(LVL_W), 2'd0, 6'(NUM_IRQ)};
      end else if (is_ctrl) begin
         for (int i = 0; i < int'(NUM_IRQ); i++) begin
            if (idx == IDX_W'(i)) begin
               rdata[0]           = ip_q[i];
               rdata[8]           = ie_q[i];
               rdata[16]          = shv_q[i];
`ifdef CLIC_EDGE_TRIG_EN
               rdata[17]          = trig_q[i];
`endif
               rdata[24 +: LVL_W] = lvl_q[i];
            end
         end
      end
   end

   assign apb_rsp_o.prdata  = rdata;
   assign apb_rsp_o.pready  = 1'b1;
   assign apb_rsp_o.pslverr = apb_req_i.psel & apb_req_i.penable & ~(is_info | is_ctrl);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ie_q  <= '0;
         shv_q <= '0;
         for (int i = 0; i < int'(NUM_IRQ); i++) begin
            lvl_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(NUM_IRQ); i++) begin
            if (ctrl_wr[i]) begin
               ie_q[i]  <= pwdata[8];
               shv_q[i] <= pwdata[16];
               lvl_q[i] <= pwdata[24 +: LVL_W];
            end
         end
      end
   end

`ifdef CLIC_EDGE_TRIG_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         trig_q  <= '0;
         src_d_q <= '0;
      end else begin
         src_d_q <= irq_src_i;
         for (int i = 0; i < int'(NUM_IRQ); i++) begin
            if (ctrl_wr[i]) begin
               trig_q[i] <= pwdata[17];
            end
         end
      end
   end
`endif

   // Pending next state; edge sources: rising edge beats SW write beats ack/mnxti clear
   always_comb begin
      ip_d = irq_src_i;
`ifdef CLIC_EDGE_TRIG_EN
      for (int i = 0; i < int'(NUM_IRQ); i++) begin
         if (trig_q[i]) begin
            ip_d[i] = ip_q[i];
            if ((irq_ack_i && (irq_id_o == ID_W'(i))) ||
                (mnxti_clr_i && (mnxti_id_i == ID_W'(i)))) begin
               ip_d[i] = 1'b0;
            end
            if (ctrl_wr[i]) begin
               ip_d[i] = pwdata[0];
            end
            if (irq_src_i[i] && !src_d_q[i]) begin
               ip_d[i] = 1'b1;
            end
         end
      end
`endif
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ip_q <= '0;
      end else begin
         ip_q <= ip_d;
      end
   end

   // Max-level search; ascending scan with >= hands ties to the highest id
   always_comb begin
      any_cand = 1'b0;
      win_id   = '0;
      win_lvl  = '0;
      win_shv  = 1'b0;
      for (int i = 0; i < int'(NUM_IRQ); i++) begin
         if (ip_q[i] && ie_q[i] && (!any_cand || (lvl_q[i] >= win_lvl))) begin
            any_cand = 1'b1;
            win_id   = ID_W'(i);
            win_lvl  = lvl_q[i];
            win_shv  = shv_q[i];
         end
      end
   end

   assign req_nxt = any_cand && (win_lvl > intthresh_i);

   // Ack suppresses the request for the following cycle so the core can raise its threshold
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         irq_req_o   <= 1'b0;
         irq_shv_o   <= 1'b0;
         irq_id_o    <= '0;
         irq_level_o <= '0;
      end else begin
         irq_req_o   <= req_nxt & ~irq_ack_i;
         irq_shv_o   <= win_shv;
         irq_id_o    <= win_id;
         irq_level_o <= win_lvl;
      end
   end

endmodule

// File: tb/tb_clic_apb_lite.sv
// Bench for clic_apb_lite: directed scenarios plus randomized traffic against a behavioural model.
// Edge-trigger scenarios run only when CLIC_EDGE_TRIG_EN is defined.
module tb_clic_apb_lite;
   localparam int NUM   = 32;
   localparam int ID_W  = 5;
   localparam int LVL_W = 8;

   logic                       clk;
   logic                       rst_n;
   logic [NUM-1:0]             src;
   CC_ITF_PKG::apb_d32_req_t   apb_req;
   CC_ITF_PKG::apb_d32_resps_t apb_rsp;
   logic                       irq_req;
   logic                       irq_shv;
   logic [ID_W-1:0]            irq_id;
   logic [LVL_W-1:0]           irq_level;
   logic                       ack;
   logic [LVL_W-1:0]           thresh;
   logic                       mclr;
   logic [ID_W-1:0]            mid;

   int n_checks = 0;
   int n_errors = 0;

   clic_apb_lite #(.NUM_IRQ(NUM), .ID_W(ID_W), .LVL_W(LVL_W)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .irq_src_i   (src),
      .apb_req_i   (apb_req),
      .apb_rsp_o   (apb_rsp),
      .irq_req_o   (irq_req),
      .irq_shv_o   (irq_shv),
      .irq_id_o    (irq_id),
      .irq_level_o (irq_level),
      .irq_ack_i   (ack),
      .intthresh_i (thresh),
      .mnxti_clr_i (mclr),
      .mnxti_id_i  (mid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit m_ip   [NUM];
   bit m_ie   [NUM];
   bit m_shv  [NUM];
   bit m_trig [NUM];
   bit m_srcd [NUM];
   int m_lvl  [NUM];
   bit m_req;
   int m_id;
   int m_wlvl;
   bit m_wshv;
   int m_best;
   int m_wr_idx;

   function automatic int ctrl_index(input logic [31:0] addr);
      logic [31:0] a;
      a = addr & 32'hFFFF_FFFC;
      if (a >= 32'h100 && a < 32'h100 + 32'(4 * NUM)) return int'((a - 32'h100) / 32'd4);
      return -1;
   endfunction

   function automatic bit m_bad(input logic [31:0] addr);
      return (ctrl_index(addr) < 0) && ((addr & 32'hFFFF_FFFC) != 32'd0);
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] addr);
      int k;
      k = ctrl_index(addr);
      if ((addr & 32'hFFFF_FFFC) == 32'd0) return 32'(NUM) | (32'(LVL_W) << 8);
      if (k < 0) return 32'd0;
      return 32'(m_ip[k]) | (32'(m_ie[k]) << 8) | (32'(m_shv[k]) << 16) |
             (32'(m_trig[k]) << 17) | (32'(m_lvl[k]) << 24);
   endfunction

   // Winner = largest (level, id) pair among pending&enabled sources
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM; i++) begin
            m_ip[i] = 0; m_ie[i] = 0; m_shv[i] = 0; m_trig[i] = 0; m_srcd[i] = 0; m_lvl[i] = 0;
         end
         m_req = 0; m_id = 0; m_wlvl = 0; m_wshv = 0;
      end else begin
         m_wr_idx = -1;
         if (apb_req.psel && apb_req.penable && apb_req.pwrite) m_wr_idx = ctrl_index(apb_req.paddr);
         m_best = -1;
         for (int i = 0; i < NUM; i++) begin
            if (m_ip[i] && m_ie[i] && (m_lvl[i] * 64 + i) > m_best) m_best = m_lvl[i] * 64 + i;
         end
         for (int i = 0; i < NUM; i++) begin
            if (!m_trig[i]) begin
               m_ip[i] = src[i];
            end else begin
               if ((ack && m_id == i) || (mclr && int'(mid) == i)) m_ip[i] = 0;
               if (m_wr_idx == i) m_ip[i] = apb_req.pwdata[0];
               if (src[i] && !m_srcd[i]) m_ip[i] = 1;
            end
            m_srcd[i] = src[i];
         end
         if (m_best >= 0) begin
            m_wlvl = m_best / 64;
            m_id   = m_best % 64;
            m_wshv = m_shv[m_id];
            m_req  = (m_wlvl > int'(thresh)) && !ack;
         end else begin
            m_wlvl = 0; m_id = 0; m_wshv = 0; m_req = 0;
         end
         if (m_wr_idx >= 0) begin
            m_ie[m_wr_idx]  = apb_req.pwdata[8];
            m_shv[m_wr_idx] = apb_req.pwdata[16];
            m_lvl[m_wr_idx] = int'(apb_req.pwdata[31:24]);
`ifdef CLIC_EDGE_TRIG_EN
            m_trig[m_wr_idx] = apb_req.pwdata[17];
`endif
         end
      end
   end

   // Cycle-by-cycle comparison of the request outputs against the model
   always @(negedge clk) begin
      if (rst_n) begin
         chk("cyc_req", 32'(irq_req), 32'(m_req));
         if (m_req) begin
            chk("cyc_id", 32'(irq_id), 32'(m_id));
            chk("cyc_lvl", 32'(irq_level), 32'(m_wlvl));
            chk("cyc_shv", 32'(irq_shv), 32'(m_wshv));
         end
      end
   end

   // ---------------- APB driver (called at a negedge) ----------------
   task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, output logic err);
      apb_req.psel = 1'b1; apb_req.penable = 1'b0; apb_req.pwrite = 1'b1;
      apb_req.paddr = addr; apb_req.pwdata = data;
      @(negedge clk);
      apb_req.penable = 1'b1;
      #1 err = apb_rsp.pslverr;
      @(negedge clk);
      apb_req.psel = 1'b0; apb_req.penable = 1'b0; apb_req.pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output logic err,
                           output logic [31:0] mdata);
      apb_req.psel = 1'b1; apb_req.penable = 1'b0; apb_req.pwrite = 1'b0;
      apb_req.paddr = addr; apb_req.pwdata = 32'd0;
      @(negedge clk);
      apb_req.penable = 1'b1;
      #1;
      data  = apb_rsp.prdata;
      err   = apb_rsp.pslverr;
      mdata = m_read(addr);
      @(negedge clk);
      apb_req.psel = 1'b0; apb_req.penable = 1'b0;
   endtask

   logic [7:0] lvl_set [6] = '{8'h00, 8'h10, 8'h40, 8'h80, 8'h90, 8'hFF};

   initial begin
      logic [31:0] rd;
      logic [31:0] md;
      logic        er;
      logic [31:0] a;
      logic [31:0] d;
      int          k;
      int          op;

      rst_n = 1'b0; src = '1; ack = 1'b0; thresh = 8'h00; mclr = 1'b0; mid = '0;
      apb_req = '0;

      // 1: reset with sources high
      repeat (3) @(negedge clk);
      chk("rst_req", 32'(irq_req), 32'd0);
      chk("rst_id", 32'(irq_id), 32'd0);
      chk("rst_lvl", 32'(irq_level), 32'd0);
      chk("rst_shv", 32'(irq_shv), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      apb_read(32'h10C, rd, er, md);
      chk("rst_ctrl3", rd, 32'h0000_0001);
      chk("rst_req_after", 32'(irq_req), 32'd0);
      src = '0;

      // 2: single source latency and threshold
      thresh = 8'h20;
      apb_write(32'h114, 32'h4001_0100, er);
      src[5] = 1'b1;
      @(negedge clk);
      chk("lat_n1_req", 32'(irq_req), 32'd0);
      @(negedge clk);
      chk("lat_n2_req", 32'(irq_req), 32'd1);
      chk("lat_id", 32'(irq_id), 32'd5);
      chk("lat_lvl", 32'(irq_level), 32'h40);
      chk("lat_shv", 32'(irq_shv), 32'd1);
      thresh = 8'h40;
      @(negedge clk);
      chk("thr_eq_req", 32'(irq_req), 32'd0);
      src[5] = 1'b0; thresh = 8'h20;
      @(negedge clk);

      // 3: tie goes to highest id, then re-point on level raise
      apb_write(32'h108, 32'h8000_0100, er);
      apb_write(32'h124, 32'h8000_0100, er);
      src[2] = 1'b1; src[9] = 1'b1;
      repeat (2) @(negedge clk);
      chk("tie_id", 32'(irq_id), 32'd9);
      chk("tie_lvl", 32'(irq_level), 32'h80);
      apb_write(32'h108, 32'h9000_0100, er);
      chk("repoint_hold", 32'(irq_req), 32'd1);
      @(negedge clk);
      chk("repoint_id", 32'(irq_id), 32'd2);
      chk("repoint_req", 32'(irq_req), 32'd1);

      // 4: ack bubble in level mode
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      chk("bubble_req", 32'(irq_req), 32'd0);
      @(negedge clk);
      chk("bubble_back", 32'(irq_req), 32'd1);

      // 5: bad addresses and INFO
      apb_read(32'h180, rd, er, md);
      chk("bad_rd_err", 32'(er), 32'd1);
      chk("bad_rd_data", rd, 32'd0);
      apb_write(32'h004, 32'hFFFF_FFFF, er);
      chk("bad_wr_err", 32'(er), 32'd1);
      apb_read(32'h108, rd, er, md);
      chk("bad_wr_ctrl2", rd, 32'h9000_0101);
      chk("ctrl_rd_err", 32'(er), 32'd0);
      apb_write(32'h000, 32'hFFFF_FFFF, er);
      chk("info_wr_err", 32'(er), 32'd0);
      apb_read(32'h000, rd, er, md);
      chk("info_rd", rd, 32'h0000_0820);

`ifdef CLIC_EDGE_TRIG_EN
      // 6: edge-triggered source
      src = '0; thresh = 8'h00;
      apb_write(32'h11C, 32'h1002_0100, er);
      src[7] = 1'b1;
      @(negedge clk);
      src[7] = 1'b0;
      @(negedge clk);
      chk("edge_req", 32'(irq_req), 32'd1);
      chk("edge_id", 32'(irq_id), 32'd7);
      apb_read(32'h11C, rd, er, md);
      chk("edge_ip_held", rd, 32'h1002_0101);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("edge_ack_drop", 32'(irq_req), 32'd0);
         @(negedge clk);
      end
      apb_write(32'h11C, 32'h1002_0101, er);
      @(negedge clk);
      chk("edge_sw_set", 32'(irq_req), 32'd1);
      ack = 1'b1; src[7] = 1'b1;
      @(negedge clk);
      ack = 1'b0; src[7] = 1'b0;
      chk("edge_ack_bubble", 32'(irq_req), 32'd0);
      @(negedge clk);
      chk("edge_beats_ack", 32'(irq_req), 32'd1);
`endif

      // Randomized traffic; the model checker compares every cycle
      for (int it = 0; it < 1500; it++) begin
         @(negedge clk);
         ack = m_req && ($urandom_range(0, 4) == 0);
`ifdef CLIC_EDGE_TRIG_EN
         mclr = ($urandom_range(0, 7) == 0);
         mid  = ID_W'($urandom_range(0, NUM - 1));
`endif
         if ($urandom_range(0, 7) == 0) begin
            src = $urandom;
         end else if ($urandom_range(0, 1) == 0) begin
            k = $urandom_range(0, NUM - 1);
            src[k] = ~src[k];
         end
         if ($urandom_range(0, 15) == 0) thresh = lvl_set[$urandom_range(0, 5)];
         op = $urandom_range(0, 11);
         if (op < 3) begin
            ack = 1'b0; mclr = 1'b0;
            k = $urandom_range(0, NUM + 3);
            a = 32'h100 + 32'(4 * k) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(0, 1023));
            d = {lvl_set[$urandom_range(0, 5)], 6'd0, 1'($urandom), 1'($urandom),
                 7'd0, 1'($urandom_range(0, 3) != 0), 7'd0, 1'($urandom)};
            apb_write(a, d, er);
            chk("rnd_wr_err", 32'(er), 32'(m_bad(a)));
         end else if (op == 3) begin
            ack = 1'b0; mclr = 1'b0;
            a = 32'h100 + 32'(4 * $urandom_range(0, NUM + 3));
            if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(0, 1023));
            apb_read(a, rd, er, md);
            chk("rnd_rd_data", rd, md);
            chk("rnd_rd_err", 32'(er), 32'(m_bad(a)));
         end
      end

      ack = 1'b0; mclr = 1'b0;
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
